// File: rtl/riscv_timer_if.sv
// Single-cycle request bus between a master and the machine timer.
// A request is valid for one cycle; the slave answers with a one-cycle ack.
interface riscv_timer_if;
    localparam int unsigned XLEN = 32;

    logic            req_i;
    logic            we_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] wdata_i;
    logic [XLEN-1:0] rdata_o;
    logic            ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface

// File: rtl/riscv_timer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// level interrupt when enabled and mtime >= mtimecmp.
module riscv_timer #(
    parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    riscv_timer_if.slave    bus,
    output logic            timer_irq_o
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned TW   = 64;
    localparam int unsigned PW   = 8;

    typedef enum logic [2:0] {
        R_MTIME_LO    = 3'd0,
        R_MTIME_HI    = 3'd1,
        R_MTIMECMP_LO = 3'd2,
        R_MTIMECMP_HI = 3'd3,
        R_CTRL        = 3'd4,
        R_STATUS      = 3'd5
    } reg_e;

    logic [TW-1:0]   mtime, mtime_nxt;
    logic [TW-1:0]   mtimecmp, mtimecmp_nxt;
    logic [XLEN-1:0] hi_shadow, hi_shadow_nxt;
    logic [PW-1:0]   presc_cnt, presc_nxt;
    logic [PW-1:0]   div, div_nxt;
    logic            en, en_nxt;
    logic [XLEN-1:0] rdata_nxt;
    logic            ack_nxt;
    logic            irq_nxt;
    logic            tick;
    logic            wr, rd;
    reg_e            sel;
    logic            unused_addr;

    assign sel         = reg_e'(bus.addr_i[4:2]);
    assign unused_addr = ^{bus.addr_i[XLEN-1:5], bus.addr_i[1:0]};

    // Next-state: prescaler tick first, bus writes override it
    always_comb begin
        mtime_nxt     = mtime;
        mtimecmp_nxt  = mtimecmp;
        hi_shadow_nxt = hi_shadow;
        presc_nxt     = presc_cnt;
        div_nxt       = div;
        en_nxt        = en;
        rdata_nxt     = bus.rdata_o;
        ack_nxt       = bus.req_i;
        irq_nxt       = en && (mtime >= mtimecmp);
        tick          = en && (presc_cnt == div);
        wr            = bus.req_i && bus.we_i;
        rd            = bus.req_i && !bus.we_i;

        if (tick) begin
            mtime_nxt = mtime + TW'(1);
            presc_nxt = '0;
        end else if (en) begin
            presc_nxt = presc_cnt + PW'(1);
        end

        if (wr) begin
            case (sel)
                R_MTIME_LO: begin
                    mtime_nxt = {mtime[TW-1:XLEN], bus.wdata_i};
                    presc_nxt = '0;
                end
                R_MTIME_HI: begin
                    mtime_nxt = {bus.wdata_i, mtime[XLEN-1:0]};
                    presc_nxt = '0;
                end
                R_MTIMECMP_LO: mtimecmp_nxt = {mtimecmp[TW-1:XLEN], bus.wdata_i};
                R_MTIMECMP_HI: mtimecmp_nxt = {bus.wdata_i, mtimecmp[XLEN-1:0]};
                R_CTRL: begin
                    en_nxt    = bus.wdata_i[0];
                    div_nxt   = bus.wdata_i[15:8];
                    presc_nxt = '0;
                end
                default: ;
            endcase
        end

        // The LO read snapshots the high word so a following HI read is coherent
        if (rd) begin
            rdata_nxt = '0;
            case (sel)
                R_MTIME_LO: begin
                    rdata_nxt     = mtime[XLEN-1:0];
                    hi_shadow_nxt = mtime[TW-1:XLEN];
                end
                R_MTIME_HI:    rdata_nxt = hi_shadow;
                R_MTIMECMP_LO: rdata_nxt = mtimecmp[XLEN-1:0];
                R_MTIMECMP_HI: rdata_nxt = mtimecmp[TW-1:XLEN];
                R_CTRL:        rdata_nxt = {16'h0000, div, 7'b0000000, en};
                R_STATUS:      rdata_nxt = {31'h0000_0000, timer_irq_o};
                default:       rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime       <= '0;
            mtimecmp    <= RST_CMP;
            hi_shadow   <= '0;
            presc_cnt   <= '0;
            div         <= '0;
            en          <= 1'b0;
            bus.rdata_o <= '0;
            bus.ack_o   <= 1'b0;
            timer_irq_o <= 1'b0;
        end else begin
            mtime       <= mtime_nxt;
            mtimecmp    <= mtimecmp_nxt;
            hi_shadow   <= hi_shadow_nxt;
            presc_cnt   <= presc_nxt;
            div         <= div_nxt;
            en          <= en_nxt;
            bus.rdata_o <= rdata_nxt;
            bus.ack_o   <= ack_nxt;
            timer_irq_o <= irq_nxt;
        end
    end
endmodule

// File: doc/riscv_timer.md
# riscv_timer

Memory-mapped RISC-V machine timer peripheral for the openrisc_sopc system. It holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register behind a simple single-cycle-request bus. It drives `timer_irq_o`, which connects to the core's `timer_irq_i` machine-timer interrupt input.

## Interface
- `RST_CMP`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `clk`, input, 1: system clock; all state is updated on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_i`, input, 1: bus request, valid for one cycle per access.
- `we_i`, input, 1: 1 = write, 0 = read; sampled with `req_i`.
- `addr_i`, input, 32: byte address; only bits [4:2] are decoded.
- `wdata_i`, input, 32: write data.
- `rdata_o`, output, 32: registered read data; valid while `ack_o` is high.
- `ack_o`, output, 1: one-cycle response pulse, for reads and writes.
- `timer_irq_o`, output, 1: registered level interrupt.

## Operation
Register map (word offset = `addr_i[4:2]`):
- 0 `MTIME_LO` (RW): `mtime`[31:0]. A read also copies `mtime`[63:32] into `hi_shadow`.
- 1 `MTIME_HI` (RW): a read returns `hi_shadow`, not the live value. A write sets `mtime`[63:32].
- 2 `MTIMECMP_LO` (RW): `mtimecmp`[31:0].
- 3 `MTIMECMP_HI` (RW): `mtimecmp`[63:32].
- 4 `CTRL` (RW): bit0 `en`; bits[15:8] `div`. All other bits read 0 and are not stored.
- 5 `STATUS` (RO): bit0 = current `timer_irq_o`. Writes are ignored.
- 6–7 are unmapped: reads return 0, writes are ignored. Every access is still acknowledged.

Prescaler:
- The 8-bit `presc_cnt` counts only while `en`=1.
- A tick occurs when `en` && `presc_cnt`==`div`. On a tick, `presc_cnt`←0 and `mtime`←`mtime`+1.
- With `en`=1, `mtime` advances every `div`+1 cycles. With `div`=0 it advances every cycle.
- `mtime` wraps from 2^64−1 to 0 silently.
- When `en`=0, both `presc_cnt` and `mtime` hold.
- A write to `CTRL` clears `presc_cnt` to 0.

Writes:
- A write to `MTIME_LO` or `MTIME_HI` takes priority over a tick in the same cycle.
- Only the addressed half changes; the other half keeps its pre-write value, with no tick carry applied.
- `presc_cnt` is cleared to 0 on either `mtime` write.
- Writes to `MTIMECMP_*` replace only the addressed half.

Interrupt:
- Every cycle, `timer_irq_o` ← `en` && (`mtime` >= `mtimecmp`), an unsigned 64-bit compare of the current register values.
- There is no latch and no clear: the interrupt is deasserted by moving `mtimecmp` above `mtime` or by clearing `en`.

Reset values:
- `rdata_o`=0, `ack_o`=0, `timer_irq_o`=0.
- `mtime`=0, `hi_shadow`=0, `presc_cnt`=0.
- `mtimecmp`=`RST_CMP`, `en`=0, `div`=0.

Reset mid-operation:
- All state returns to its reset value asynchronously.
- Any pending `ack_o` is dropped.

## Timing
Bus access:
- A request sampled at edge N gives `ack_o`=1 and `rdata_o` valid during cycle N+1.
- Writes take effect at edge N, so a read issued in the next cycle sees the new value.
- Back-to-back requests on every cycle are legal. Each request gets exactly one ack, one cycle later.
- When `ack_o`=0, `rdata_o` holds its last value; masters must ignore it.
- A read of `MTIME_LO` returns `mtime` as it was before edge N. `hi_shadow` captures the high word at the same edge, so a LO read followed by a HI read gives a coherent 64-bit value.

Interrupt timing:
- `timer_irq_o` rises one edge after the compare first becomes true.
- Example: `mtime` reaches `mtimecmp` at edge K; `timer_irq_o`=1 from edge K+1.
- It falls one edge after a `mtimecmp` write that makes the compare false.

## Test plan
- **Reset:** assert `rst` mid-count with `en`=1, `mtime`=0x1234 → all outputs 0 immediately; `mtime` reads back 0 and `mtimecmp` reads 0xFFFFFFFF_FFFFFFFF.
- **Prescaler:** write `CTRL`=0x0301 (`div`=3, `en`=1) and wait 40 cycles → `mtime` = 10 (±1 for the write-cycle alignment). With `CTRL`=0x0001, `mtime` increments every cycle.
- **Interrupt:** set `mtimecmp`=20 and `mtime`=0, then write `CTRL`=0x1 → `timer_irq_o` rises exactly one cycle after `mtime`==20 and `STATUS` reads 1. Writing `MTIMECMP_LO`=1000 drops `timer_irq_o` one cycle later.
- **Wrap and coherent read:** write `mtime`=0xFFFFFFFF_FFFFFFFE with `en`=1 and `div`=0 → after 2 cycles `mtime`=0. A LO read at `mtime`=0x00000000_FFFFFFFF, followed by a HI read after the carry, returns HI=0 (the shadow), not 1.
- **Write vs. tick collision:** with a tick occurring in the same cycle, write `MTIME_LO`=5 → `mtime`[31:0]=5, the high word is unchanged, and the next tick occurs `div`+1 cycles later.
- **Bus corners:** issue back-to-back read/write/read on consecutive cycles → three acks on consecutive cycles. An unmapped address 0x18 read returns 0, still acks, and changes no state. A write to `STATUS` is ignored.
